max3_stream: RTL

- Sequential, streaming counterpart of the team's combinational 3-input max comparator.
- Accepts operand bytes one at a time over a valid/ready handshake and assembles them into a triple x, y, z.
- Computes the strict maximum of the triple and presents the result over an output valid/ready handshake.
- Sits between a byte source (switches, UART RX, test sequencer) and a display or result consumer.

---
 rtl/max3_stream.sv | 115 +++++++++++
 1 files changed

// File: rtl/max3_stream.sv
// Streaming 3-operand strict-maximum unit: collects x, y, z over a valid/ready
// input, then holds the winner and its index on a valid/ready output.
module max3_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       triple_cnt
);

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_Y,
    LOAD_Z,
    CMP,
    HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, y, z;
  logic [WIDTH-1:0] win_data;
  logic [1:0]       win_idx;
  logic             accept;
  logic             consume;

  // in_ready depends only on the state register, so it never combinationally
  // follows in_valid.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    consume   = 1'b0;
    case (state)
      LOAD_X: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD_Y;
      end
      LOAD_Y: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD_Z;
      end
      LOAD_Z: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CMP;
      end
      CMP:  state_nxt = HOLD;
      HOLD: begin
        consume = out_ready;
        if (out_ready) state_nxt = LOAD_X;
      end
      default: state_nxt = LOAD_X;
    endcase
  end

  assign accept = in_valid && in_ready;

  // A tie for the maximum, including all three equal, reports no winner.
  always_comb begin
    win_data = '0;
    win_idx  = 2'd0;
    if (x > y && x > z) begin
      win_data = x;
      win_idx  = 2'd1;
    end else if (y > x && y > z) begin
      win_data = y;
      win_idx  = 2'd2;
    end else if (z > x && z > y) begin
      win_data = z;
      win_idx  = 2'd3;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_X;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      out_data   <= '0;
      out_idx    <= 2'd0;
      out_valid  <= 1'b0;
      triple_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        case (state)
          LOAD_X:  x <= in_data;
          LOAD_Y:  y <= in_data;
          LOAD_Z:  z <= in_data;
          default: ;
        endcase
      end
      if (state == CMP) begin
        out_data  <= win_data;
        out_idx   <= win_idx;
        out_valid <= 1'b1;
      end
      if (consume) begin
        out_valid  <= 1'b0;
        triple_cnt <= triple_cnt + 8'd1;
      end
    end
  end

endmodule
